sar_search: RTL and testbench
=============================

# sar_search

Successive-approximation search controller: the initiating side of the 4-bit magnitude comparator interface. It drives a trial value into a comparator's B input and consumes the EQ/GT/LT flags, where A is an unknown target, to recover that target by binary search. Conversion takes at most WIDTH decision cycles and terminates early on EQ. It sits between a control FSM, which issues start and reads the result, and a combinational magnitude comparator.

## Interface
- WIDTH, 4, width of trial/result; the comparator operand width.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a search; sampled only in IDLE.
- eq_in  input  1  comparator EQ (A == trial).
- gt_in  input  1  comparator GT (A > trial).
- lt_in  input  1  comparator LT (A < trial).
- trial  output  WIDTH  value driven to the comparator B input.
- busy  output  1  high in TEST.
- done  output  1  one-cycle pulse; result and err are valid.
- result  output  WIDTH  recovered target; held until the next accepted start.
- err  output  1  illegal flag combination seen in the last search; held like result.

## Operation
- States:
  - IDLE: busy=0, trial=0.
  - TEST: busy=1, trial = acc | mask.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Registers:
  - acc (WIDTH): bits confirmed so far.
  - mask (WIDTH): one-hot, the bit under test.
- IDLE & start: acc<=0, mask<=1<<(WIDTH-1), err<=0, go to TEST.
- TEST decision each cycle. Flags must be exactly one-hot; otherwise:
  - err<=1, result<=acc, go to DONE.
- TEST with legal flags:
  - eq_in: result<=trial, go to DONE (early exit).
  - gt_in: acc<=trial, keeping the tested bit.
  - lt_in: acc unchanged, dropping the tested bit.
  - If mask[0] (last bit): result<=updated acc, go to DONE. Otherwise mask<=mask>>1.
- trial is never 0 in TEST. Target 0 therefore resolves via all-LT, with result 0.
- start in TEST or DONE is ignored; it is not queued.
- Reset mid-search aborts it: all registers return to reset values and no done pulse is issued.
- Reset values: state IDLE, trial 0, busy 0, done 0, result 0, err 0, acc 0, mask 0.

## Timing
- Flags are sampled combinationally in the same cycle trial is presented. Comparator path: trial reg -> comparator -> flags -> next-state logic, all in one cycle.
- Edge k samples start. trial is valid after edge k. Decisions occur at edges k+1 .. k+n, where n ≤ WIDTH.
- done is high in the cycle after the final decision edge, so start-to-done latency is n+1 edges.
- Next start is accepted at the edge following the done cycle. Throughput is one search per n+2 cycles.
- result and err update at the final decision edge and are stable while done is high and afterwards.

## Structure
- Shared package sar_pkg:
  - state enum (IDLE, TEST, DONE).
  - default WIDTH constant.
  - FLAGS_OK helper: one-hot check of {eq,gt,lt}.
- Single flat module. No RTL sub-module is needed.
- The bench instantiates the team's 4-bit magnitude comparator as the target model, with A = target register and B = trial.

## Test plan
- Target 11: trials 8 (GT), 12 (LT), 10 (GT), 11 (EQ). done at edge k+5, result=11, err=0.
- Target 0: trials 8, 4, 2, 1, all LT. result=0 after 4 decisions, no EQ seen.
- Target 8: trial 8 gives EQ on the first decision. done at edge k+2, result=8. Target 15: trials 8, 12, 14, 15, result=15.
- start held high continuously: searches run back-to-back with one IDLE cycle between them. start pulses during busy/done are ignored, and result is unchanged until the next done.
- Force eq_in=gt_in=1 on the second decision of target 11: err=1, result=8, done pulses.
- Assert rst during the third decision: all outputs go to 0 asynchronously and no done pulse occurs. A fresh search after release returns the correct target.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

  localparam int SAR_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TEST = 2'd1,
    S_DONE = 2'd2
  } sar_state_e;

  // Comparator flags are only trustworthy when exactly one of them is set.
  function automatic logic flags_ok(input logic eq, input logic gt, input logic lt);
    logic ok;
    case ({eq, gt, lt})
      3'b100, 3'b010, 3'b001: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sar_search.sv
// Binary-search controller: drives trial values to a magnitude comparator and
// recovers the comparator's unknown A operand from its EQ/GT/LT flags.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             eq_in,
  input  logic             gt_in,
  input  logic             lt_in,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshake: start is a level sampled only while IDLE; a search is
  // complete when done is high for one cycle, and result/err are valid
  // from that cycle until the next accepted start.

  sar_state_e       state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] trial_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] acc_d;
  logic             legal;

  always_comb begin
    acc_d = acc_q;
    if (gt_in) acc_d = trial_q;
  end

  assign legal = flags_ok(eq_in, gt_in, lt_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mask_q   <= '0;
      trial_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q   <= '0;
            mask_q  <= MSB_ONLY;
            trial_q <= MSB_ONLY;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_TEST;
          end
        end
        S_TEST: begin
          if (!legal || eq_in || mask_q[0]) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            trial_q <= '0;
            if (!legal) begin
              err_q    <= 1'b1;
              result_q <= acc_q;
            end else if (eq_in) begin
              result_q <= trial_q;
            end else begin
              acc_q    <= acc_d;
              result_q <= acc_d;
            end
          end else begin
            // Next trial keeps confirmed bits and tests the next lower one.
            acc_q   <= acc_d;
            mask_q  <= mask_q >> 1;
            trial_q <= acc_d | (mask_q >> 1);
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign trial     = trial_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: a comparator model answers the trials; searches are
// checked against an arithmetic model of binary search.
module tb_sar_search;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         eq_in, gt_in, lt_in;
  logic [W-1:0] trial;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;
  logic [1:0]   dbg_state;

  logic [W-1:0] target_q;
  logic         fault_en;
  logic [2:0]   fault_flags;

  int tests;
  int fails;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] target;
    int           exp_n;
    logic [W-1:0] exp_result;
  } vec_t;

  vec_t vecs[6];

  sar_search #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .eq_in(eq_in), .gt_in(gt_in), .lt_in(lt_in),
    .trial(trial), .busy(busy), .done(done),
    .result(result), .err(err), .dbg_state(dbg_state)
  );

  // Magnitude comparator: A = target, B = trial, with an override for faults.
  always_comb begin
    if (fault_en) begin
      {eq_in, gt_in, lt_in} = fault_flags;
    end else begin
      eq_in = (target_q == trial);
      gt_in = (target_q >  trial);
      lt_in = (target_q <  trial);
    end
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Decision count of a binary search: EQ hits once the trial equals the
  // target, i.e. when the target's lowest set bit is under test.
  function automatic int model_n(input logic [W-1:0] tgt);
    int tz;
    if (tgt == 0) return W;
    tz = 0;
    while (tgt[tz] == 1'b0) tz++;
    return W - tz;
  endfunction

  // Trial at decision i: target bits above the tested bit, plus the tested bit.
  function automatic logic [W-1:0] model_trial(input logic [W-1:0] tgt, input int i);
    int b;
    int keep;
    logic [W-1:0] hi;
    b    = W - i;
    keep = (1 << W) - (1 << (b + 1));
    hi   = tgt & keep[W-1:0];
    return hi | W'(1 << b);
  endfunction

  // driver: one full search from IDLE, checked decision by decision
  task automatic run_search(input logic [W-1:0] tgt, input int exp_n);
    int  dec;
    logic got_done;
    @(negedge clk);
    target_q = tgt;
    start    = 1'b1;
    exp_q.push_back(tgt);
    @(negedge clk);
    start    = 1'b0;
    dec      = 0;
    got_done = 1'b0;
    for (int c = 0; c < W + 2 && !got_done; c++) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        dec++;
        check("busy_in_test", busy, 1);
        check("trial", trial, model_trial(tgt, dec));
        @(negedge clk);
      end
    end
    check("done_seen", got_done, 1);
    check("decisions", dec, exp_n);
    check("result", result, exp_q.pop_front());
    check("err_clear", err, 0);
    check("busy_at_done", busy, 0);
    check("trial_at_done", trial, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", dbg_state, 0);
    check("result_held", result, tgt);
  endtask

  initial begin
    int pulses;
    int last_c;
    int waited;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    start = 1'b0;
    target_q = '0;
    fault_en = 1'b0;
    fault_flags = 3'b000;

    vecs[0] = '{4'd11, 4, 4'd11};
    vecs[1] = '{4'd0,  4, 4'd0};
    vecs[2] = '{4'd8,  1, 4'd8};
    vecs[3] = '{4'd15, 4, 4'd15};
    vecs[4] = '{4'd12, 2, 4'd12};
    vecs[5] = '{4'd5,  4, 4'd5};

    repeat (2) @(negedge clk);
    check("rst_trial", trial, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;

    // table-driven searches
    for (int i = 0; i < 6; i++) begin
      run_search(vecs[i].target, vecs[i].exp_n);
      check("table_result", result, vecs[i].exp_result);
    end

    // randomized targets against the model
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] t;
      t = W'($urandom_range(0, (1 << W) - 1));
      run_search(t, model_n(t));
    end

    // start held high: back-to-back searches, period n+2
    @(negedge clk);
    target_q = 4'd6;
    start = 1'b1;
    pulses = 0;
    last_c = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) begin
        check("b2b_result", result, 6);
        if (last_c >= 0) check("b2b_period", c - last_c, model_n(4'd6) + 2);
        last_c = c;
        pulses++;
      end
    end
    check("b2b_pulses_min", (pulses >= 3), 1);
    start = 1'b0;
    waited = 0;
    while (dbg_state != 2'd0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("b2b_back_to_idle", dbg_state, 0);

    // start pulses during busy and done are ignored
    run_search(4'd11, 4);
    @(negedge clk);
    target_q = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      check("ign_busy", busy, 1);
      check("ign_result_held", result, 11);
      start = (d == 2);
      @(negedge clk);
    end
    check("ign_done", done, 1);
    check("ign_result", result, 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_done_cycle_start", dbg_state, 0);
    @(negedge clk);
    check("ign_no_restart", dbg_state, 0);
    check("ign_no_restart_busy", busy, 0);
    check("ign_result_after", result, 3);

    // illegal flags on second decision of target 11
    @(negedge clk);
    target_q = 4'd11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("flt_trial1", trial, 8);
    @(negedge clk);
    check("flt_trial2", trial, 12);
    fault_flags = 3'b110;
    fault_en = 1'b1;
    @(negedge clk);
    fault_en = 1'b0;
    check("flt_done", done, 1);
    check("flt_err", err, 1);
    check("flt_result", result, 8);
    @(negedge clk);
    check("flt_done_drop", done, 0);
    check("flt_err_held", err, 1);
    run_search(4'd9, model_n(4'd9));

    // reset during the third decision aborts the search
    @(negedge clk);
    target_q = 4'd11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstm_trial3", trial, 10);
    rst = 1'b1;
    #1;
    check("rstm_trial", trial, 0);
    check("rstm_busy", busy, 0);
    check("rstm_done", done, 0);
    check("rstm_result", result, 0);
    check("rstm_err", err, 0);
    check("rstm_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rstm_no_done", done, 0);
    end
    run_search(4'd11, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
